pixel_burst_writer: RTL and testbench

- Sits directly downstream of the colour-transform stage. Consumes its wrreq / x / y / RGB pixel stream.
- Buffers pixels in a small synchronous FIFO and converts raster coordinates to linear frame-buffer addresses.
- Issues fixed-length write bursts to the SDRAM frame-buffer controller using a request/acknowledge plus valid/ready handshake.

---
 rtl/frame_pkg.sv | 31 +++
 rtl/pixel_sync_fifo.sv | 74 +++++++
 rtl/pixel_burst_writer.sv | 163 ++++++++++++++++
 tb/tb_pixel_burst_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared frame geometry, pixel record layout and writer FSM states for the
// frame-buffer write path.
package frame_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int RGB_W        = 24;
  localparam int COORD_W      = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [RGB_W-1:0]   rgb;
  } pixel_t;

  localparam int PIX_W = $bits(pixel_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } wr_state_e;

  // burst_len is a power of two, so the low bits decide alignment
  function automatic logic is_aligned(input logic [COORD_W-1:0] x, input int burst_len);
    logic [COORD_W-1:0] mask;
    mask = COORD_W'(burst_len - 1);
    return (x & mask) == {COORD_W{1'b0}};
  endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock pixel FIFO; the head entry is read straight from storage and a
// push together with a pop is accepted even when full.
module pixel_sync_fifo #(
  parameter  int WIDTH = 44,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_25,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  // Occupancy, pointers and storage next-state
  always_comb begin
    pop_ok_s  = pop && (level_q != {LVL_W{1'b0}});
    push_ok_s = push && ((level_q != LVL_W'(DEPTH)) || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == {LVL_W{1'b0}});
  assign level = level_q;

endmodule

// File: rtl/pixel_burst_writer.sv
// Buffers in-range pixels and writes them to the frame buffer as fixed-length,
// BURST_LEN-aligned bursts over a req/ack + valid/ready interface.
module pixel_burst_writer
  import frame_pkg::*;
#(
  parameter  int H_ACTIVE   = H_ACTIVE_DEF,
  parameter  int V_ACTIVE   = V_ACTIVE_DEF,
  parameter  int FIFO_DEPTH = 16,
  parameter  int BURST_LEN  = 8,
  parameter  int BASE_ADDR  = 0,
  parameter  int ADDR_W     = 22,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_25,
  input  logic              reset,
  input  logic              wrreq_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic [7:0]        red_i,
  input  logic [7:0]        green_i,
  input  logic [7:0]        blue_i,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              mem_wvalid,
  output logic [23:0]       mem_wdata,
  input  logic              mem_wready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              frame_done
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  pixel_t            in_pix_s, head_pix_s;
  logic [PIX_W-1:0]  head_raw_s;
  logic              in_range_s, push_s, pop_s;
  logic              full_s, empty_s;
  logic              head_aligned_s, head_last_s;
  logic [LVL_W-1:0]  level_s;
  logic [ADDR_W-1:0] head_addr_s;

  wr_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              wvalid_q, wvalid_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;

  // Range filter and head-of-queue decode
  always_comb begin
    in_pix_s       = {x_i, y_i, red_i, green_i, blue_i};
    in_range_s     = (32'(x_i) < H_ACTIVE) && (32'(y_i) < V_ACTIVE);
    push_s         = wrreq_i && in_range_s;
    head_pix_s     = pixel_t'(head_raw_s);
    head_aligned_s = is_aligned(head_pix_s.x, BURST_LEN);
    head_last_s    = (32'(head_pix_s.x) == H_ACTIVE - 1) &&
                     (32'(head_pix_s.y) == V_ACTIVE - 1);
    // Truncating ADDR_W-bit arithmetic is intended
    head_addr_s    = ADDR_W'(BASE_ADDR) +
                     (ADDR_W'(head_pix_s.y) * ADDR_W'(H_ACTIVE)) +
                     ADDR_W'(head_pix_s.x);
  end

  pixel_sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_25 (clk_25),
    .reset  (reset),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (in_pix_s),
    .rdata  (head_raw_s),
    .full   (full_s),
    .empty  (empty_s),
    .level  (level_s)
  );

  // Burst FSM, beat counter and status flags
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    req_d        = 1'b0;
    wvalid_d     = 1'b0;
    pop_s        = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s && !head_aligned_s) begin
          pop_s = 1'b1;
        end else if (level_s >= LVL_W'(BURST_LEN)) begin
          state_d = REQ;
          addr_d  = head_addr_s;
          req_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d  = DATA;
          beat_d   = {BEAT_W{1'b0}};
          wvalid_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      DATA: begin
        wvalid_d = 1'b1;
        if (mem_wready) begin
          pop_s        = 1'b1;
          frame_done_d = head_last_s;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d  = IDLE;
            beat_d   = {BEAT_W{1'b0}};
            wvalid_d = 1'b0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = {BEAT_W{1'b0}};
      end
    endcase
    overflow_d = overflow_q | (push_s && full_s && !pop_s);
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= {BEAT_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      req_q        <= 1'b0;
      wvalid_q     <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      wvalid_q     <= wvalid_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign mem_wvalid = wvalid_q;
  assign mem_wdata  = wvalid_q ? head_pix_s.rgb : {RGB_W{1'b0}};
  assign fifo_level = level_s;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_burst_writer.sv
// Directed and randomized bench for pixel_burst_writer, scored against a
// queue-based model of the filter / discard / burst rules.
module tb_pixel_burst_writer;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BL = 8;

  logic        clk_25 = 1'b0;
  logic        reset = 1'b0;
  logic        wrreq_i = 1'b0;
  logic [9:0]  x_i = 10'd0, y_i = 10'd0;
  logic [7:0]  red_i = 8'd0, green_i = 8'd0, blue_i = 8'd0;
  logic        mem_req, mem_wvalid, overflow, frame_done;
  logic [21:0] mem_addr;
  logic        mem_ack = 1'b0, mem_wready = 1'b1;
  logic [23:0] mem_wdata;
  logic [4:0]  fifo_level;

  pixel_burst_writer dut (
    .clk_25(clk_25), .reset(reset), .wrreq_i(wrreq_i), .x_i(x_i), .y_i(y_i),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .fifo_level(fifo_level), .overflow(overflow), .frame_done(frame_done)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct { int x; int y; logic [23:0] rgb; } pix_t;

  pix_t        pend_q[$];
  pix_t        exp_beats[$];
  int unsigned exp_addr[$];
  pix_t        mon_p;

  int n_checks = 0, n_pass = 0;
  int ack_mode = 1, ack_delay = 2, wr_mode = 0;
  int beats_seen = 0, fd_count = 0;
  int resp_rc = 0;
  bit resp_ph = 1'b0;
  bit fd_pend = 1'b0, prev_hold = 1'b0, prev_req_wait = 1'b0;
  logic [23:0] hold_data;
  logic [21:0] hold_addr;
  int unsigned last_addr = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: drop out-of-range, discard misaligned heads, group by BL.
  function automatic void model_push(int x, int y, logic [23:0] rgb);
    pix_t p;
    if (x >= H || y >= V) return;
    p.x = x; p.y = y; p.rgb = rgb;
    pend_q.push_back(p);
    while (pend_q.size() != 0) begin
      if (pend_q[0].x % BL != 0) begin
        void'(pend_q.pop_front());
        continue;
      end
      if (pend_q.size() < BL) break;
      exp_addr.push_back(int'(pend_q[0].y * H + pend_q[0].x));
      for (int k = 0; k < BL; k++) exp_beats.push_back(pend_q.pop_front());
    end
  endfunction

  task automatic drive_pix(int x, int y, logic [23:0] rgb, bit drop, bit pace);
    int budget = 200;
    @(negedge clk_25);
    while (pace && fifo_level >= 5'd14 && budget > 0) begin
      wrreq_i = 1'b0;
      @(negedge clk_25);
      budget--;
    end
    if (pace) chk("pace_timeout", 64'(budget > 0), 64'd1);
    wrreq_i = 1'b1;
    x_i = 10'(x); y_i = 10'(y);
    {red_i, green_i, blue_i} = rgb;
    if (!drop) model_push(x, y, rgb);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk_25);
      wrreq_i = 1'b0;
    end
  endtask

  task automatic wait_drain(string tag);
    int budget = 2000;
    idle(1);
    while ((exp_beats.size() != 0 || exp_addr.size() != 0) && budget > 0) begin
      @(negedge clk_25);
      budget--;
    end
    chk({tag, "_drain"}, 64'(budget > 0), 64'd1);
    idle(4);
    chk({tag, "_level"}, 64'(fifo_level), 64'(pend_q.size()));
  endtask

  // Controller responder: delayed ack, selectable wready pattern
  initial begin
    forever begin
      @(negedge clk_25);
      if (ack_mode == 1 && mem_req) begin
        mem_ack = (resp_rc >= ack_delay);
        resp_rc++;
      end else begin
        mem_ack = 1'b0;
        resp_rc = 0;
      end
      case (wr_mode)
        1: begin
          if (!mem_wvalid) begin
            resp_ph = 1'b0;
            mem_wready = 1'b1;
          end else begin
            mem_wready = !resp_ph;
            resp_ph = !resp_ph;
          end
        end
        2: mem_wready = 1'($urandom_range(0, 1));
        default: mem_wready = 1'b1;
      endcase
    end
  end

  // Monitor: samples just before each rising edge
  initial begin
    forever begin
      @(negedge clk_25);
      #15;
      if (!reset) begin
        fd_pend = 1'b0; prev_hold = 1'b0; prev_req_wait = 1'b0;
      end else begin
        chk("frame_done", 64'(frame_done), 64'(fd_pend));
        fd_pend = 1'b0;
        if (frame_done) fd_count++;
        if (prev_hold) begin
          chk("hold_wvalid", 64'(mem_wvalid), 64'd1);
          chk("hold_wdata", 64'(mem_wdata), 64'(hold_data));
        end
        if (prev_req_wait) begin
          chk("hold_req", 64'(mem_req), 64'd1);
          chk("hold_addr", 64'(mem_addr), 64'(hold_addr));
        end
        if (mem_req && mem_ack) begin
          last_addr = 32'(mem_addr);
          chk("burst_expected", 64'(exp_addr.size() > 0), 64'd1);
          if (exp_addr.size() > 0) chk("burst_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
        end
        if (mem_wvalid && mem_wready) begin
          beats_seen++;
          chk("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
          if (exp_beats.size() > 0) begin
            mon_p = exp_beats.pop_front();
            chk("beat_wdata", 64'(mem_wdata), 64'(mon_p.rgb));
            fd_pend = (mon_p.x == H - 1) && (mon_p.y == V - 1);
          end
        end
        prev_hold = mem_wvalid && !mem_wready;
        hold_data = mem_wdata;
        prev_req_wait = mem_req && !mem_ack;
        hold_addr = mem_addr;
      end
    end
  end

  initial begin
    int base, budget, gx, gy, ns;
    #30;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk_25);
    reset = 1'b1;

    // single burst
    ack_delay = 2; wr_mode = 0;
    for (int i = 0; i < 8; i++) drive_pix(i, 0, 24'(i + 1), 1'b0, 1'b0);
    wait_drain("single");
    chk("single_addr", 64'(last_addr), 64'd0);

    // backpressure
    wr_mode = 1; base = beats_seen;
    for (int i = 0; i < 8; i++) drive_pix(i, 0, 24'(i + 1), 1'b0, 1'b0);
    wait_drain("backpressure");
    chk("bp_beats", 64'(beats_seen - base), 64'd8);

    // out of range
    wr_mode = 0;
    drive_pix(640, 0, 24'h123456, 1'b0, 1'b0);
    drive_pix(0, 480, 24'h654321, 1'b0, 1'b0);
    idle(3);
    chk("oor_level", 64'(fifo_level), 64'd0);
    chk("oor_overflow", 64'(overflow), 64'd0);

    // frame end
    base = fd_count;
    for (int i = 632; i < 640; i++) drive_pix(i, 479, 24'($urandom), 1'b0, 1'b0);
    wait_drain("frame_end");
    chk("frame_addr", 64'(last_addr), 64'd307192);
    chk("frame_done_count", 64'(fd_count - base), 64'd1);

    // overflow with ack withheld
    ack_mode = 0;
    for (int i = 0; i < 17; i++) drive_pix(i, 0, 24'($urandom), i == 16, 1'b0);
    idle(2);
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    idle(5);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    ack_mode = 1;
    wait_drain("overflow");
    chk("ovf_sticky_after", 64'(overflow), 64'd1);
    chk("ovf_last_addr", 64'(last_addr), 64'd8);

    // reset during beat 3
    base = beats_seen; budget = 200;
    for (int i = 0; i < 8; i++) drive_pix(i, 1, 24'($urandom), 1'b0, 1'b0);
    idle(1);
    while (beats_seen < base + 3 && budget > 0) begin
      @(negedge clk_25);
      budget--;
    end
    chk("mid_reach_beat3", 64'(budget > 0), 64'd1);
    #5 reset = 1'b0;
    #1;
    chk("mid_wvalid", 64'(mem_wvalid), 64'd0);
    chk("mid_req", 64'(mem_req), 64'd0);
    chk("mid_level", 64'(fifo_level), 64'd0);
    chk("mid_overflow", 64'(overflow), 64'd0);
    chk("mid_wdata", 64'(mem_wdata), 64'd0);
    pend_q.delete(); exp_beats.delete(); exp_addr.delete();
    @(negedge clk_25);
    reset = 1'b1;
    for (int i = 16; i < 24; i++) drive_pix(i, 5, 24'($urandom), 1'b0, 1'b0);
    wait_drain("post_reset");
    chk("post_reset_addr", 64'(last_addr), 64'd3216);

    // randomized groups with strays, out-of-range pixels and random wready
    wr_mode = 2;
    for (int g = 0; g < 12; g++) begin
      ack_delay = int'($urandom_range(0, 3));
      ns = int'($urandom_range(0, 2));
      for (int s = 0; s < ns; s++)
        drive_pix(8 * int'($urandom_range(0, 78)) + int'($urandom_range(1, 7)),
                  int'($urandom_range(0, 479)), 24'($urandom), 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0)
        drive_pix(int'($urandom_range(640, 1023)), int'($urandom_range(0, 479)),
                  24'($urandom), 1'b0, 1'b1);
      gx = (g == 5) ? 632 : 8 * int'($urandom_range(0, 79));
      gy = (g == 5) ? 479 : int'($urandom_range(0, 479));
      for (int j = 0; j < 8; j++) drive_pix(gx + j, gy, 24'($urandom), 1'b0, 1'b1);
    end
    wait_drain("random");
    chk("random_overflow", 64'(overflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
